// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch unit: owns the PC, keeps one fetch in flight to instruction
// memory, and hands each fetched word plus its PC to decode over valid/ready.
// Redirects from branch/jump/trap resolution replace the PC and discard any
// fetch that the new PC makes stale.
module ysyx_22040088_ifu #(
  parameter int unsigned      XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic             clk,
  input  logic             rst_n,

  // Instruction memory request channel
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,

  // Instruction memory response channel
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,

  // Decode-side handshake
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_pc,

  // PC redirect from execute / trap logic
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,

  // Delivered-instruction counter
  output logic [63:0]      fetch_cnt
);

  localparam int unsigned INST_W  = 32;
  localparam int unsigned CNT_W   = 64;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] S_BOOT = 2'd0;
  localparam logic [STATE_W-1:0] S_REQ  = 2'd1;
  localparam logic [STATE_W-1:0] S_WAIT = 2'd2;
  localparam logic [STATE_W-1:0] S_FULL = 2'd3;

  localparam logic [INST_W-1:0]  INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0]    PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0]    ALIGN_MASK = ~XLEN'(3);

  // Registered state
  logic [STATE_W-1:0] state_q,     state_d;
  logic [XLEN-1:0]    pc_q,        pc_d;
  logic               kill_q,      kill_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [INST_W-1:0]  inst_q,      inst_d;
  logic [XLEN-1:0]    opc_q,       opc_d;
  logic               req_valid_q, req_valid_d;
  logic               out_valid_q, out_valid_d;

  // Per-cycle events derived from the current state and inputs
  logic               req_fire;
  logic               rsp_seen;
  logic               rsp_drop;
  logic               rsp_take;
  logic               redir;
  logic               out_fire;
  logic [XLEN-1:0]    redir_tgt;

  // Decode this cycle's handshakes and redirect qualification
  always_comb begin : event_decode
    req_fire  = (state_q == S_REQ) && imem_req_ready;
    rsp_seen  = (state_q == S_WAIT) && imem_rsp_valid;
    rsp_drop  = rsp_seen && (kill_q || redirect_valid);
    rsp_take  = rsp_seen && !kill_q && !redirect_valid;
    redir     = redirect_valid && (state_q != S_BOOT);
    out_fire  = (state_q == S_FULL) && out_ready && !redirect_valid;
    redir_tgt = redirect_pc & ALIGN_MASK;
  end

  // Fetch sequencing: BOOT -> REQ -> WAIT -> FULL -> REQ
  always_comb begin : state_next
    state_d = state_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_drop) begin
          state_d = S_REQ;
        end else if (rsp_take) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (redirect_valid || out_ready) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // PC: redirect target wins, otherwise advance on a delivered instruction
  always_comb begin : pc_next
    pc_d = pc_q;
    if (redir) begin
      pc_d = redir_tgt;
    end else if (out_fire) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // Kill marks the outstanding response as belonging to a superseded PC
  always_comb begin : kill_next
    kill_d = kill_q;
    case (state_q)
      S_REQ: begin
        if (req_fire) begin
          kill_d = redirect_valid;
        end
      end
      S_WAIT: begin
        if (rsp_seen) begin
          kill_d = 1'b0;
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      default: begin
        kill_d = kill_q;
      end
    endcase
  end

  // Capture a live response into the decode holding register
  always_comb begin : capture_next
    inst_d = inst_q;
    opc_d  = opc_q;
    if (rsp_take) begin
      inst_d = imem_rsp_data;
      opc_d  = pc_q;
    end
  end

  // Count instructions actually accepted by decode
  always_comb begin : cnt_next
    cnt_d = cnt_q;
    if (out_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Handshake valids are registered copies of the next-state decode
  always_comb begin : valid_next
    req_valid_d = (state_d == S_REQ);
    out_valid_d = (state_d == S_FULL);
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      cnt_q       <= '0;
      inst_q      <= INST_NOP;
      opc_q       <= RESET_PC;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      cnt_q       <= cnt_d;
      inst_q      <= inst_d;
      opc_q       <= opc_d;
      req_valid_q <= req_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign out_valid      = out_valid_q;
  assign out_inst       = inst_q;
  assign out_pc         = opc_q;
  assign fetch_cnt      = cnt_q;

endmodule
